// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: registered one-hot grant, per-client burst credit, stall freeze.
// Optional WRR_ARBITER_LOCK_EN adds a lock input that extends the current holder's burst.

module wrr_lane #(
    parameter int IDX      = 0,
    parameter int IDX_W    = 2,
    parameter int WEIGHT_W = 4
) (
    input  logic                req,
    input  logic [IDX_W-1:0]    ptr,
    input  logic [WEIGHT_W-1:0] weight,
    output logic                upper,
    output logic [WEIGHT_W-1:0] ew
);
    localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(IDX);

    // A request at or above ptr belongs to the first search window.
    assign upper = req && (MY_IDX >= ptr);
    assign ew    = (weight == '0) ? WEIGHT_W'(1) : weight;
endmodule

module wrr_arbiter #(
    parameter int CLIENTS  = 32,
    parameter int WEIGHT_W = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CLIENTS-1:0]            request,
    input  logic [CLIENTS*WEIGHT_W-1:0]   weight,
    input  logic                          stall,
`ifdef WRR_ARBITER_LOCK_EN
    input  logic                          lock,
`endif
    output logic [CLIENTS-1:0]            grant,
    output logic [$clog2(CLIENTS)-1:0]    grant_id,
    output logic                          grant_vld
);
    localparam int IDX_W = $clog2(CLIENTS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(CLIENTS - 1);

    logic [IDX_W-1:0]                   ptr;
    logic [WEIGHT_W-1:0]                credit;
    logic [CLIENTS-1:0]                 upper;
    logic [CLIENTS-1:0][WEIGHT_W-1:0]   ew;

    logic                               hit_upper;
    logic [IDX_W-1:0]                   j_upper;
    logic [IDX_W-1:0]                   j_any;
    logic [IDX_W-1:0]                   sel;
    logic                               any_req;
    logic                               holder_req;
    logic                               lock_hold;
    logic                               do_hold;
    logic [WEIGHT_W-1:0]                credit_hold;
    logic [CLIENTS-1:0]                 sel_onehot;
    logic [IDX_W-1:0]                   ptr_next;

    genvar gi;
    generate
        for (gi = 0; gi < CLIENTS; gi++) begin : g_lane
            wrr_lane #(
                .IDX      (gi),
                .IDX_W    (IDX_W),
                .WEIGHT_W (WEIGHT_W)
            ) u_lane (
                .req    (request[gi]),
                .ptr    (ptr),
                .weight (weight[gi*WEIGHT_W +: WEIGHT_W]),
                .upper  (upper[gi]),
                .ew     (ew[gi])
            );
        end
    endgenerate

    // Lowest set bit of each window; descending loop leaves the lowest index last.
    always_comb begin
        hit_upper = 1'b0;
        j_upper   = '0;
        j_any     = '0;
        for (int i = CLIENTS - 1; i >= 0; i--) begin
            if (upper[i]) begin
                hit_upper = 1'b1;
                j_upper   = IDX_W'(i);
            end
            if (request[i]) begin
                j_any = IDX_W'(i);
            end
        end
    end

    assign any_req    = |request;
    assign sel        = hit_upper ? j_upper : j_any;
    assign sel_onehot = CLIENTS'(1) << sel;
    assign ptr_next   = (sel == LAST) ? '0 : sel + IDX_W'(1);
    assign holder_req = grant_vld && request[grant_id];

`ifdef WRR_ARBITER_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    // Under lock the credit may already be zero; it saturates there.
    assign do_hold     = holder_req && ((credit != '0) || lock_hold);
    assign credit_hold = (credit == '0) ? '0 : credit - WEIGHT_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant     <= '0;
            grant_id  <= '0;
            grant_vld <= 1'b0;
            ptr       <= '0;
            credit    <= '0;
        end else if (!stall) begin
            if (do_hold) begin
                credit <= credit_hold;
            end else if (any_req) begin
                grant     <= sel_onehot;
                grant_id  <= sel;
                grant_vld <= 1'b1;
                credit    <= ew[sel] - WEIGHT_W'(1);
                ptr       <= ptr_next;
            end else begin
                grant     <= '0;
                grant_id  <= '0;
                grant_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed-vector bench for wrr_arbiter at CLIENTS=4, WEIGHT_W=3.
// Lock vectors are included only when WRR_ARBITER_LOCK_EN is defined.

module tb_wrr_arbiter;
    localparam int CL = 4;
    localparam int WW = 3;

    typedef struct {
        logic              rst;
        logic [CL-1:0]     req;
        logic [CL*WW-1:0]  wt;
        logic              stl;
        logic              lck;
        logic [CL-1:0]     exp;
    } vec_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [CL-1:0]     request = '0;
    logic [CL*WW-1:0]  weight = '0;
    logic              stall = 1'b0;
    logic              lock = 1'b0;
    logic [CL-1:0]     grant;
    logic [1:0]        grant_id;
    logic              grant_vld;

    int compared = 0;
    int mismatched = 0;
    vec_t vecs[$];

    wrr_arbiter #(.CLIENTS(CL), .WEIGHT_W(WW)) dut (
        .clock     (clock),
        .reset     (reset),
        .request   (request),
        .weight    (weight),
        .stall     (stall),
`ifdef WRR_ARBITER_LOCK_EN
        .lock      (lock),
`endif
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    always #5 clock = ~clock;

    function automatic logic [1:0] id_of(input logic [CL-1:0] g);
        for (int i = 0; i < CL; i++) if (g[i]) return 2'(i);
        return 2'd0;
    endfunction

    function automatic vec_t mk(input logic r, input logic [CL-1:0] q, input logic [CL*WW-1:0] w,
                                input logic s, input logic l, input logic [CL-1:0] e);
        vec_t v;
        v.rst = r; v.req = q; v.wt = w; v.stl = s; v.lck = l; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [CL-1:0] exp);
        compared++;
        if (grant !== exp || grant_id !== id_of(exp) || grant_vld !== (|exp)) begin
            mismatched++;
            $display("FAIL %s: got grant=%b id=%0d vld=%b, want grant=%b id=%0d vld=%b",
                     name, grant, grant_id, grant_vld, exp, id_of(exp), |exp);
        end
        compared++;
        if (!$onehot0(grant)) begin
            mismatched++;
            $display("FAIL %s onehot0: got grant=%b, want zero or one-hot", name, grant);
        end
    endtask

    task automatic pulse_reset(input string name);
        request = '0;
        stall   = 1'b0;
        lock    = 1'b0;
        reset   = 1'b1;
        #2;
        check(name, '0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic step(input string name, input vec_t v);
        request = v.req;
        weight  = v.wt;
        stall   = v.stl;
        lock    = v.lck;
        @(posedge clock);
        #1;
        check(name, v.exp);
    endtask

    initial begin
        // 1: lone client 2, w=3, self-regrants continuously
        vecs.push_back(mk(1, 4'b0000, 12'h000, 0, 0, 4'b0000));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 4'b0100, 12'h0C0, 0, 0, 4'b0100));
        // 2: w0=2, w1=3 -> 0,0,1,1,1,0,0,1,1,1
        vecs.push_back(mk(1, 4'b0000, 12'h000, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0011, 12'h01A, 0, 0, 4'b0001));
        vecs.push_back(mk(0, 4'b0011, 12'h01A, 0, 0, 4'b0001));
        vecs.push_back(mk(0, 4'b0011, 12'h01A, 0, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b0011, 12'h01A, 0, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b0011, 12'h01A, 0, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b0011, 12'h01A, 0, 0, 4'b0001));
        vecs.push_back(mk(0, 4'b0011, 12'h01A, 0, 0, 4'b0001));
        vecs.push_back(mk(0, 4'b0011, 12'h01A, 0, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b0011, 12'h01A, 0, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b0011, 12'h01A, 0, 0, 4'b0010));
        // 3: all request, zero weights -> one cycle each; idle keeps ptr
        vecs.push_back(mk(1, 4'b0000, 12'h000, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 12'h000, 0, 0, 4'b0001));
        vecs.push_back(mk(0, 4'b1111, 12'h000, 0, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b1111, 12'h000, 0, 0, 4'b0100));
        vecs.push_back(mk(0, 4'b1111, 12'h000, 0, 0, 4'b1000));
        vecs.push_back(mk(0, 4'b1111, 12'h000, 0, 0, 4'b0001));
        vecs.push_back(mk(0, 4'b0000, 12'h000, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 12'h000, 0, 0, 4'b0010));
        // 4: client 3 burst, then wrap to 0 (ptr then 1, so 3 is next)
        vecs.push_back(mk(1, 4'b0000, 12'h000, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b1000, 12'h400, 0, 0, 4'b1000));
        vecs.push_back(mk(0, 4'b1001, 12'h400, 0, 0, 4'b1000));
        vecs.push_back(mk(0, 4'b1001, 12'h400, 0, 0, 4'b0001));
        vecs.push_back(mk(0, 4'b1001, 12'h400, 0, 0, 4'b1000));
        // 5: client 1 w=4 stalled 5 cycles after its 2nd cycle
        vecs.push_back(mk(1, 4'b0000, 12'h000, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0110, 12'h020, 0, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b0110, 12'h020, 0, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b0110, 12'h020, 1, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b0000, 12'h020, 1, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b0110, 12'h020, 1, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b0110, 12'h020, 1, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b0110, 12'h020, 1, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b0110, 12'h020, 0, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b0110, 12'h020, 0, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b0110, 12'h020, 0, 0, 4'b0100));
`ifdef WRR_ARBITER_LOCK_EN
        // 8: lock holds client 0 past its single-cycle weight
        vecs.push_back(mk(1, 4'b0000, 12'h000, 0, 0, 4'b0000));
        for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 4'b0011, 12'h001, 0, 1, 4'b0001));
        vecs.push_back(mk(0, 4'b0011, 12'h001, 0, 0, 4'b0010));
`endif

        #3;
        check("reset_state", '0);
        @(negedge clock);
        reset = 1'b0;

        for (int n = 0; n < vecs.size(); n++) begin
            if (vecs[n].rst) pulse_reset($sformatf("vec%0d_reset", n));
            else step($sformatf("vec%0d", n), vecs[n]);
        end

        // 6: async reset between edges mid-burst, then lowest-index requestor wins
        pulse_reset("s6_pre");
        step("s6_a", mk(0, 4'b0110, 12'h038, 0, 0, 4'b0010));
        step("s6_b", mk(0, 4'b0110, 12'h038, 0, 0, 4'b0010));
        #2;
        reset = 1'b1;
        #1;
        check("s6_async", '0);
        @(negedge clock);
        reset = 1'b0;
        step("s6_after", mk(0, 4'b0110, 12'h038, 0, 0, 4'b0010));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
